// File: rtl/btb_pkg.sv
// Shared types and defaults for the BTB update path: entry layout and
// sequencer states.
package btb_pkg;

  localparam int ENTRIES = 8;
  localparam int OFFSET  = 2;
  localparam int QDEPTH  = 4;

  // Same packing as a BTB entry: {valid, target, pc}, 65 bits.
  typedef struct packed {
    logic        valid;
    logic [31:0] target;
    logic [31:0] pc;
  } btb_wr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

endpackage

// File: rtl/btb_update_fifo.sv
// Small synchronous FIFO of pending BTB writes with a one-cycle clear used
// when a flush sweep starts.
module btb_update_fifo
  import btb_pkg::*;
#(
  parameter int QDEPTH = btb_pkg::QDEPTH
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clear,
  input  logic    push,
  input  btb_wr_t push_data,
  input  logic    pop,
  output btb_wr_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(QDEPTH);

  btb_wr_t       mem [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port sequencer: filters resolved branches into BTB updates,
// drains them one per cycle, and runs the full-table invalidate sweep.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int ENTRIES = btb_pkg::ENTRIES,
  parameter int OFFSET  = btb_pkg::OFFSET,
  parameter int QDEPTH  = btb_pkg::QDEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       resolve_valid,
  output logic                       resolve_ready,
  input  logic [31:0]                resolve_pc,
  input  logic [31:0]                resolve_target,
  input  logic                       resolve_taken,
  input  logic                       pred_taken,
  input  logic [31:0]                pred_target,
  input  logic                       flush_req,
  output logic                       flush_busy,
  output logic                       btb_wr_en,
  output logic [$clog2(ENTRIES)-1:0] btb_wr_index,
  output logic                       btb_wr_valid,
  output logic [31:0]                btb_wr_pc,
  output logic [31:0]                btb_wr_target,
  output logic                       mispredict,
  output logic [31:0]                resolve_count,
  output logic [31:0]                mispredict_count,
  output state_e                     dbg_state
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [IDX:0] SWEEP_END = (IDX+1)'(ENTRIES);

  // Handshake: an event transfers on a rising edge where resolve_valid and
  // resolve_ready are both high; ready never looks at valid.

  state_e         state_q;
  logic [IDX:0]   sweep_cnt;
  logic           is_mp;
  logic           accept;
  logic           needs_update;
  logic           enq;
  logic           sweep_start;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic           issue;
  btb_wr_t        new_entry;
  btb_wr_t        fifo_head;
  btb_wr_t        issue_entry;

  assign resolve_ready = !fifo_full && (state_q != ST_SWEEP) && !flush_req;
  assign dbg_state     = state_q;

  always_comb begin
    is_mp        = (resolve_taken != pred_taken) ||
                   (resolve_taken && pred_taken && (resolve_target != pred_target));
    accept       = resolve_valid && resolve_ready;
    needs_update = (resolve_taken && is_mp) || (!resolve_taken && pred_taken);
    enq          = accept && needs_update;
    sweep_start  = flush_req && (state_q != ST_SWEEP);

    new_entry        = '0;
    new_entry.valid  = resolve_taken;
    new_entry.target = resolve_target;
    new_entry.pc     = resolve_pc;

    // An empty queue lets the new entry bypass straight to the write port
    // so a fresh update reaches the BTB in the cycle after acceptance.
    fifo_pop    = !sweep_start && (state_q != ST_SWEEP) && !fifo_empty;
    fifo_push   = enq && !fifo_empty;
    issue       = fifo_pop || (enq && fifo_empty);
    issue_entry = fifo_empty ? new_entry : fifo_head;
  end

  btb_update_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (sweep_start),
    .push     (fifo_push),
    .push_data(new_entry),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sweep_cnt     <= '0;
      flush_busy    <= 1'b0;
      btb_wr_en     <= 1'b0;
      btb_wr_index  <= '0;
      btb_wr_valid  <= 1'b0;
      btb_wr_pc     <= '0;
      btb_wr_target <= '0;
    end else if (sweep_start) begin
      state_q       <= ST_SWEEP;
      flush_busy    <= 1'b1;
      btb_wr_en     <= 1'b1;
      btb_wr_index  <= '0;
      btb_wr_valid  <= 1'b0;
      btb_wr_pc     <= '0;
      btb_wr_target <= '0;
      sweep_cnt     <= {{IDX{1'b0}}, 1'b1};
    end else if (state_q == ST_SWEEP) begin
      // sweep_cnt is the next index to clear; reaching ENTRIES ends the sweep.
      if (sweep_cnt == SWEEP_END) begin
        state_q      <= ST_IDLE;
        flush_busy   <= 1'b0;
        btb_wr_en    <= 1'b0;
        btb_wr_index <= '0;
        sweep_cnt    <= '0;
      end else begin
        btb_wr_en    <= 1'b1;
        btb_wr_index <= sweep_cnt[IDX-1:0];
        sweep_cnt    <= sweep_cnt + 1'b1;
      end
    end else begin
      btb_wr_en <= issue;
      state_q   <= issue ? ST_DRAIN : ST_IDLE;
      if (issue) begin
        btb_wr_index  <= issue_entry.pc[IDX+OFFSET-1:OFFSET];
        btb_wr_valid  <= issue_entry.valid;
        btb_wr_pc     <= issue_entry.pc;
        btb_wr_target <= issue_entry.target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict       <= 1'b0;
      resolve_count    <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= accept && is_mp;
      if (accept)          resolve_count    <= resolve_count + 32'd1;
      if (accept && is_mp) mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: queue-based reference model of BTB writes,
// flush sweeps and counters, checked by a free-running monitor.
module tb_btb_update_ctrl;
  import btb_pkg::*;

  localparam int IDX = $clog2(ENTRIES);
  localparam int W   = 32 + IDX + 1 + 32 + 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            resolve_valid = 1'b0;
  logic            resolve_ready;
  logic [31:0]     resolve_pc = '0;
  logic [31:0]     resolve_target = '0;
  logic            resolve_taken = 1'b0;
  logic            pred_taken = 1'b0;
  logic [31:0]     pred_target = '0;
  logic            flush_req = 1'b0;
  logic            flush_busy;
  logic            btb_wr_en;
  logic [IDX-1:0]  btb_wr_index;
  logic            btb_wr_valid;
  logic [31:0]     btb_wr_pc;
  logic [31:0]     btb_wr_target;
  logic            mispredict;
  logic [31:0]     resolve_count;
  logic [31:0]     mispredict_count;
  state_e          dbg_state;

  btb_update_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .resolve_valid   (resolve_valid),
    .resolve_ready   (resolve_ready),
    .resolve_pc      (resolve_pc),
    .resolve_target  (resolve_target),
    .resolve_taken   (resolve_taken),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .flush_req       (flush_req),
    .flush_busy      (flush_busy),
    .btb_wr_en       (btb_wr_en),
    .btb_wr_index    (btb_wr_index),
    .btb_wr_valid    (btb_wr_valid),
    .btb_wr_pc       (btb_wr_pc),
    .btb_wr_target   (btb_wr_target),
    .mispredict      (mispredict),
    .resolve_count   (resolve_count),
    .mispredict_count(mispredict_count),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: each expected write is {cycle, index, valid, pc, target}
  logic [W-1:0] exp_q[$];
  int          cyc = 0;
  int          busy_until = -1;
  int          last_wr = -1;
  logic [31:0] m_rc = '0;
  logic [31:0] m_mc = '0;
  logic        m_mp = 1'b0;

  always @(posedge clk) begin
    bit m_ready;
    bit mp;
    bit upd;
    int wc;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      busy_until = -1;
      last_wr    = -1;
      m_rc       = '0;
      m_mc       = '0;
      m_mp       = 1'b0;
    end else begin
      m_ready = !((cyc - 1) <= busy_until) && !flush_req;
      m_mp    = 1'b0;
      if (flush_req && !((cyc - 1) <= busy_until)) begin
        exp_q.delete();
        for (int i = 0; i < ENTRIES; i++)
          exp_q.push_back({32'(cyc + i), IDX'(i), 1'b0, 32'h0, 32'h0});
        busy_until = cyc + ENTRIES - 1;
        last_wr    = busy_until;
      end else if (resolve_valid && m_ready) begin
        mp  = (resolve_taken != pred_taken) ||
              (resolve_taken && pred_taken && resolve_target != pred_target);
        upd = (resolve_taken && mp) || (!resolve_taken && pred_taken);
        m_rc++;
        if (mp) m_mc++;
        m_mp = mp;
        if (upd) begin
          wc = (last_wr + 1 > cyc) ? last_wr + 1 : cyc;
          exp_q.push_back({32'(wc), resolve_pc[IDX+OFFSET-1:OFFSET], resolve_taken,
                           resolve_pc, resolve_target});
          last_wr = wc;
        end
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (int'(e[W-1:W-32]) == cyc) begin
          void'(exp_q.pop_front());
          chk("wr_en", btb_wr_en, 1);
          chk("wr_index", btb_wr_index, e[64+IDX:65]);
          chk("wr_valid", btb_wr_valid, e[64]);
          chk("wr_pc", btb_wr_pc, e[63:32]);
          chk("wr_target", btb_wr_target, e[31:0]);
        end else begin
          chk("wr_en_quiet", btb_wr_en, 0);
        end
      end else begin
        chk("wr_en_quiet", btb_wr_en, 0);
      end
      chk("mispredict", mispredict, m_mp);
      chk("flush_busy", flush_busy, cyc <= busy_until);
      chk("resolve_ready", resolve_ready, !(cyc <= busy_until) && !flush_req);
      chk("resolve_count", resolve_count, m_rc);
      chk("mispredict_count", mispredict_count, m_mc);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                      input logic ptk, input logic [31:0] ptgt);
    resolve_valid  = 1'b1;
    resolve_pc     = pc;
    resolve_target = tgt;
    resolve_taken  = tk;
    pred_taken     = ptk;
    pred_target    = ptgt;
    step();
    resolve_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic flush();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_en"}, btb_wr_en, 0);
    chk({tag, "_wr_index"}, btb_wr_index, 0);
    chk({tag, "_wr_valid"}, btb_wr_valid, 0);
    chk({tag, "_wr_pc"}, btb_wr_pc, 0);
    chk({tag, "_wr_target"}, btb_wr_target, 0);
    chk({tag, "_mispredict"}, mispredict, 0);
    chk({tag, "_flush_busy"}, flush_busy, 0);
    chk({tag, "_resolve_count"}, resolve_count, 0);
    chk({tag, "_mispredict_count"}, mispredict_count, 0);
    chk({tag, "_ready"}, resolve_ready, 1);
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // first mispredict, correct prediction, taken -> not-taken
    send(32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    send(32'h104, 32'h300, 1'b1, 1'b1, 32'h300);
    send(32'h108, 32'h40c, 1'b0, 1'b1, 32'h500);
    idle(3);

    // five back-to-back mispredicts
    for (int i = 0; i < 5; i++)
      send(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), 1'b1, 1'b0, 32'h0);
    idle(2);

    // flush right behind a burst of updates
    for (int i = 0; i < 3; i++)
      send(32'h3000 + 32'(i * 4), 32'h4000, 1'b1, 1'b1, 32'h4004);
    flush();
    flush();
    idle(10);

    // randomized traffic with occasional flushes
    for (int n = 0; n < 600; n++) begin
      resolve_valid  = ($urandom_range(0, 3) != 0);
      resolve_pc     = 32'($urandom_range(0, 255)) << 2;
      resolve_taken  = 1'($urandom_range(0, 1));
      pred_taken     = 1'($urandom_range(0, 1));
      resolve_target = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300;
      pred_target    = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300;
      flush_req      = ($urandom_range(0, 49) == 0);
      step();
    end
    resolve_valid = 1'b0;
    flush_req     = 1'b0;
    idle(12);

    // reset in the fourth sweep cycle
    send(32'h110, 32'h210, 1'b1, 1'b0, 32'h0);
    flush();
    idle(3);
    #3 rst_n = 1'b0;
    #1 check_reset_values("mid_sweep_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'h10c, 32'h600, 1'b1, 1'b0, 32'h0);
    idle(12);

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
